serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences a single 1-bit full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first.
- Provides a start/busy/done handshake, latches the operands, holds the carry in a flip-flop and registers the final sum/carry.
- Sits between a requester (lab top or test driver) and the full-adder cell. It replaces a WIDTH-bit ripple adder where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- cin  input  1  carry-in; latched on accepted start
- busy  output  1  high while state is ADD
- done  output  1  one-cycle pulse, high while state is DONE
- sum  output  WIDTH  registered result of the last completed add
- cout  output  1  registered carry-out of the last completed add

Behaviour:
- One clock. Reset is asynchronous and active-high. No synchronous reset.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal opA/opB/acc shift registers=0, carry FF=0, bit counter=0.
- States: IDLE, ADD, DONE (2-bit encoding, encoding free).
- IDLE:
  - If start=1 at edge E0: opA<=a, opB<=b, carry<=cin, cnt<=0, state<=ADD.
  - Otherwise stay in IDLE.
- ADD, each edge:
  - bit s = opA[0]^opB[0]^carry.
  - carry <= majority(opA[0],opB[0],carry).
  - acc <= {s, acc[WIDTH-1:1]}; opA and opB shift right by 1.
  - cnt <= cnt+1.
- ADD exit: on the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - sum <= final acc value including this edge's bit.
  - cout <= new carry.
  - state <= DONE.
- DONE: done=1 for exactly one cycle, then state<=IDLE unconditionally.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH clocks after the start-sampling edge.
- Minimum start-to-start period is WIDTH+2 clocks.
- start in ADD or DONE is ignored (not queued). start held high continuously gives back-to-back operations, each sampled in IDLE.
- a/b/cin changes after E0 have no effect on the running operation.
- sum/cout change only on the ADD->DONE edge. They hold the previous result throughout ADD and IDLE.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1 is reachable.
- rst asserted mid-operation:
  - Immediate return to IDLE with all reset values, including sum/cout cleared.
  - No done pulse is issued for the aborted operation.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as bit WIDTH: {cout,sum} = a+b+cin.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow). It is registered alongside sum/cout on the ADD->DONE edge.
  - ovf resets to 0 and is cleared by mid-operation reset.
- Undefined: port ovf is absent, and no MSB-carry capture logic is generated.

Test Plan:
- Reset: hold rst=1 for 3 clocks with random a/b/start -> busy=0, done=0, sum=8'h00, cout=0 throughout.
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulsed one cycle -> busy high for 8 cycles, done pulses exactly 8 clocks after start edge, sum=8'h10, cout=0; with SERIAL_ADD_OVF_EN, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
- start held high, first op a=8'h12, b=8'h34; change a/b to 8'hAA/8'h55 one cycle after acceptance -> first done gives sum=8'h46; second op accepted exactly WIDTH+2 clocks after the first gives sum=8'hFF, cout=0.
- a=8'hF0, b=8'h0F, cin=1, assert rst asynchronously mid-clock after 3 ADD edges -> busy falls immediately, no done pulse, sum=0, cout=0. A fresh start then completes normally.
- WIDTH=4 exhaustive: all 512 (a,b,cin) combinations -> {cout,sum} equals a+b+cin for every operation, with done once per op.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Runs one 1-bit full-adder cell over two WIDTH-bit operands, LSB first,
// one bit per clock, behind a start/busy/done handshake.
// Optional build macro: SERIAL_ADD_OVF_EN adds the registered output ovf
// (two's-complement overflow of the last completed add).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    // Only WIDTH-1 result bits need storing; the final bit is merged in on
    // the exit edge straight from the adder cell.
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-adder cell on the current LSBs and the carry flip-flop.
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] acc_shift;

    assign fa_s      = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign fa_c      = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
    assign acc_shift = {fa_s, acc_q};

    // Register all state; every register clears on reset, including the result.
    // NOTE: datapath registers are reset too, so an aborted add leaves no stale sum/cout visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath control: accept in IDLE, shift in ADD, pulse in DONE.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path can infer a latch.
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                carry_d = fa_c;
                acc_d   = acc_shift[WIDTH-1:1];
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = acc_shift;
                    cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB, fa_c the carry out of it.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance for handshake,
// table vectors and corner sequences, and a 4-bit instance swept exhaustively.
module tb_serial_add_ctrl;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         start, cin, busy, done, cout;
    logic [W-1:0] a, b, sum;
    logic          start4, cin4, busy4, done4, cout4;
    logic [W4-1:0] a4, b4, sum4;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf, ovf4;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf4),
`endif
        .cout  (cout4)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete 8-bit operation with a start pulse; inputs are scrambled
    // right after acceptance to prove the operands were latched.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input logic ev, input string nm);
        int n;
        int busy_n;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc;
        check({nm, " busy after accept"}, 64'(busy), 64'(1'b1));
        check({nm, " sum held"}, 64'(sum), 64'(prev_sum));
        check({nm, " cout held"}, 64'(cout), 64'(prev_cout));
        n = 0;
        busy_n = 1;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        check({nm, " done latency"}, 64'(n), 64'(W));
        check({nm, " busy cycles"}, 64'(busy_n), 64'(W));
        check({nm, " sum"}, 64'(sum), 64'(es));
        check({nm, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({nm, " ovf"}, 64'(ovf), 64'(ev));
`else
        if (ev === 1'bx) $display("unexpected x in vector %s", nm);
`endif
        @(negedge clk);
        check({nm, " done single pulse"}, 64'(done), 64'(1'b0));
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        int n;
        logic [4:0] e4;
        logic       v4;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #1 rst = 1'b1;

        // Reset held for three clocks with random stimulus.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset busy %0d", i), 64'(busy), 64'(1'b0));
            check($sformatf("reset done %0d", i), 64'(done), 64'(1'b0));
            check($sformatf("reset sum %0d", i), 64'(sum), 64'(8'h00));
            check($sformatf("reset cout %0d", i), 64'(cout), 64'(1'b0));
            check($sformatf("reset busy4 %0d", i), 64'(busy4), 64'(1'b0));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("reset ovf %0d", i), 64'(ovf), 64'(1'b0));
`endif
            a = 8'($urandom); b = 8'($urandom); start = 1'($urandom); cin = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum, vecs[i].ecout,
                   vecs[i].eovf, $sformatf("vec%0d", i));
        end

        // start held high: back-to-back operations, operands changed mid-op.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        check("held busy first", 64'(busy), 64'(1'b1));
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        check("held first latency", 64'(n), 64'(W));
        check("held first sum", 64'(sum), 64'(8'h46));
        check("held first cout", 64'(cout), 64'(1'b0));
        @(negedge clk);
        check("held idle gap busy", 64'(busy), 64'(1'b0));
        check("held idle gap done", 64'(done), 64'(1'b0));
        @(negedge clk);
        check("held second accepted", 64'(busy), 64'(1'b1));
        check("held sum kept during add", 64'(sum), 64'(8'h46));
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        check("held second latency", 64'(n), 64'(W));
        check("held second sum", 64'(sum), 64'(8'hFF));
        check("held second cout", 64'(cout), 64'(1'b0));
        start = 1'b0;
        @(negedge clk);
        check("held done single pulse", 64'(done), 64'(1'b0));

        // Asynchronous reset in the middle of an add, after three ADD edges.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'(1'b0));
        check("abort done", 64'(done), 64'(1'b0));
        check("abort sum", 64'(sum), 64'(8'h00));
        check("abort cout", 64'(cout), 64'(1'b0));
`ifdef SERIAL_ADD_OVF_EN
        check("abort ovf", 64'(ovf), 64'(1'b0));
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("abort no done or busy", 64'(n), 64'(0));
        prev_sum  = '0;
        prev_cout = 1'b0;
        run_op(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, "after abort");

        // Exhaustive sweep of the 4-bit instance.
        for (int x = 0; x < 512; x++) begin
            @(negedge clk);
            a4 = x[3:0]; b4 = x[7:4]; cin4 = x[8]; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 20) begin @(negedge clk); n++; end
            e4 = 5'(a4) + 5'(b4) + 5'(cin4);
            v4 = (a4[3] == b4[3]) && (e4[3] != a4[3]);
            check($sformatf("w4 latency %0d", x), 64'(n), 64'(W4));
            check($sformatf("w4 result %0d", x), 64'({cout4, sum4}), 64'(e4));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("w4 ovf %0d", x), 64'(ovf4), 64'(v4));
`else
            if (v4 === 1'bx) $display("unexpected x in w4 model %0d", x);
`endif
            @(negedge clk);
            check($sformatf("w4 done single %0d", x), 64'(done4), 64'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
